// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO pad configuration slice: word layout,
// reset default and the serial load counter states.
package gpio_cfg_pkg;

  localparam int unsigned CFG_W  = 13;
  localparam int unsigned BCNT_W = 4;

  localparam int unsigned MGMT_ENA_BIT    = 0;
  localparam int unsigned OEB_OVR_BIT     = 1;
  localparam int unsigned HOLD_OVR_BIT    = 2;
  localparam int unsigned INP_DIS_BIT     = 3;
  localparam int unsigned IB_MODE_SEL_BIT = 4;
  localparam int unsigned ANALOG_EN_BIT   = 5;
  localparam int unsigned ANALOG_SEL_BIT  = 6;
  localparam int unsigned ANALOG_POL_BIT  = 7;
  localparam int unsigned SLOW_SEL_BIT    = 8;
  localparam int unsigned VTRIP_SEL_BIT   = 9;
  localparam int unsigned DM_LSB          = 10;
  localparam int unsigned DM_MSB          = 12;

  localparam logic [CFG_W-1:0] PAD_CTRL_DEFAULT = 13'h0403;

  typedef struct packed {
    logic [2:0] dm;
    logic       vtrip_sel;
    logic       slow_sel;
    logic       analog_pol;
    logic       analog_sel;
    logic       analog_en;
    logic       ib_mode_sel;
    logic       inp_dis;
    logic       hold_ovr;
    logic       oeb_ovr;
    logic       mgmt_ena;
  } pad_ctrl_t;

  typedef enum logic [1:0] {
    CNT_EMPTY   = 2'd0,
    CNT_PARTIAL = 2'd1,
    CNT_FULL    = 2'd2
  } cnt_state_e;

endpackage : gpio_cfg_pkg

// File: rtl/gpio_cfg_shifter.sv
// Serial shift register, saturating bit counter and validated shadow load
// for one pad in the configuration daisy chain.
module gpio_cfg_shifter
  import gpio_cfg_pkg::*;
(
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             data_i,
  input  logic             shift_i,
  input  logic             load_i,
  output logic             data_o,
  output logic [CFG_W-1:0] shadow_o,
  output logic             load_ok_o,
  output logic             load_err_o
);

  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(CFG_W - 1);

  cnt_state_e        state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [CFG_W-1:0]  shreg_q, shreg_d;
  pad_ctrl_t         shadow_q, shadow_d;
  logic              load_ok_q, load_ok_d;
  logic              load_err_q, load_err_d;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= CNT_EMPTY;
      bcnt_q     <= '0;
      shreg_q    <= PAD_CTRL_DEFAULT;
      shadow_q   <= pad_ctrl_t'(PAD_CTRL_DEFAULT);
      load_ok_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      shreg_q    <= shreg_d;
      shadow_q   <= shadow_d;
      load_ok_q  <= load_ok_d;
      load_err_q <= load_err_d;
    end
  end

  // Load takes priority over shift; a load always empties the counter.
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    shreg_d    = shreg_q;
    shadow_d   = shadow_q;
    load_ok_d  = 1'b0;
    load_err_d = 1'b0;
    if (load_i) begin
      state_d = CNT_EMPTY;
      bcnt_d  = '0;
      if (state_q == CNT_FULL) begin
        shadow_d  = pad_ctrl_t'(shreg_q);
        load_ok_d = 1'b1;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (shift_i) begin
      shreg_d = {shreg_q[CFG_W-2:0], data_i};
      case (state_q)
        CNT_EMPTY: begin
          state_d = CNT_PARTIAL;
          bcnt_d  = BCNT_W'(1);
        end
        CNT_PARTIAL: begin
          bcnt_d = bcnt_q + BCNT_W'(1);
          if (bcnt_q == BCNT_LAST) begin
            state_d = CNT_FULL;
          end
        end
        CNT_FULL: begin
          state_d = CNT_FULL;
        end
        default: begin
          state_d = CNT_EMPTY;
          bcnt_d  = '0;
        end
      endcase
    end
  end

  assign data_o     = shreg_q[CFG_W-1];
  assign shadow_o   = shadow_q;
  assign load_ok_o  = load_ok_q;
  assign load_err_o = load_err_q;

endmodule : gpio_cfg_shifter

// File: rtl/gpio_pad_config.sv
// Per-pad configuration register: serial-loaded control word plus the
// management/user data mux in front of the pad cell.
module gpio_pad_config
  import gpio_cfg_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_data_in,
  input  logic             serial_shift,
  input  logic             serial_load,
  output logic             serial_data_out,
  output logic             load_ok,
  output logic             load_err,
  output logic [CFG_W-1:0] pad_ctrl,
  input  logic             mgmt_gpio_out,
  input  logic             mgmt_gpio_oeb,
  input  logic             user_gpio_out,
  input  logic             user_gpio_oeb,
  input  logic             pad_gpio_in,
  output logic             pad_gpio_out,
  output logic             pad_gpio_oeb,
  output logic             mgmt_gpio_in,
  output logic             user_gpio_in
);

  logic [CFG_W-1:0] shadow;

  gpio_cfg_shifter u_shifter (
    .clock_i    (clock),
    .reset_i    (reset),
    .data_i     (serial_data_in),
    .shift_i    (serial_shift),
    .load_i     (serial_load),
    .data_o     (serial_data_out),
    .shadow_o   (shadow),
    .load_ok_o  (load_ok),
    .load_err_o (load_err)
  );

  assign pad_ctrl = shadow;

  // Route pad data to the owning side; inp_dis blanks both receive paths.
  always_comb begin
    pad_gpio_out = 1'b0;
    pad_gpio_oeb = 1'b1;
    mgmt_gpio_in = 1'b0;
    user_gpio_in = 1'b0;
    if (shadow[MGMT_ENA_BIT]) begin
      pad_gpio_out = mgmt_gpio_out;
      pad_gpio_oeb = mgmt_gpio_oeb | shadow[OEB_OVR_BIT];
      mgmt_gpio_in = pad_gpio_in & ~shadow[INP_DIS_BIT];
    end else begin
      pad_gpio_out = user_gpio_out;
      pad_gpio_oeb = user_gpio_oeb | shadow[OEB_OVR_BIT];
      user_gpio_in = pad_gpio_in & ~shadow[INP_DIS_BIT];
    end
  end

endmodule : gpio_pad_config

// File: doc/gpio_pad_config.md
# gpio_pad_config

Per-pad configuration register for the user-area GPIO ring, sitting directly downstream of the buffered 1.8 V constant tie-off cells and upstream of each I/O pad cell. Holds a 13-bit pad-control word loaded through a daisy-chained serial shift path from housekeeping, with a shadow register that updates only on a validated load strobe. Drives the pad mode/enable pins and muxes pad data between management and user ports according to the latched `mgmt_ena` bit. On reset, all pad controls come up at a safe default, so pads never see undefined control levels.

## Interface
- `CFG_W`, 13, configuration word width; fixed, other values unsupported.
- `PAD_CTRL_DEFAULT`, 13'h0403, reset value of both shift and shadow registers: `dm`=3'b001, `oeb_ovr`=1, `mgmt_ena`=1, all other bits 0.
- `clock`  in  1  serial configuration clock; all flops on the rising edge.
- `reset`  in  1  asynchronous, active-high reset; deassertion synchronous to `clock` externally.
- `serial_data_in`  in  1  serial config bit, MSB first.
- `serial_shift`  in  1  shift enable.
- `serial_load`  in  1  single-cycle load strobe; copies shift register to shadow.
- `serial_data_out`  out  1  registered `shreg[12]`, feeds the next pad in the chain.
- `load_ok`  out  1  one-cycle pulse, load accepted.
- `load_err`  out  1  one-cycle pulse, load rejected (count ≠ 13).
- `pad_ctrl`  out  13  shadow word: [0] `mgmt_ena`, [1] `oeb_ovr`, [2] `hold_ovr`, [3] `inp_dis`, [4] `ib_mode_sel`, [5] `analog_en`, [6] `analog_sel`, [7] `analog_pol`, [8] `slow_sel`, [9] `vtrip_sel`, [12:10] `dm`.
- `mgmt_gpio_out`, `mgmt_gpio_oeb`  in  1 each  management-side data and output-enable.
- `user_gpio_out`, `user_gpio_oeb`  in  1 each  user-side data and output-enable.
- `pad_gpio_in`  in  1  pad receive data.
- `pad_gpio_out`, `pad_gpio_oeb`  out  1 each  to the pad cell.
- `mgmt_gpio_in`, `user_gpio_in`  out  1 each  pad data returned to each side.

## Operation
- Shift register `shreg[12:0]`, shadow `shadow[12:0]`, and bit counter `bcnt[3:0]` (0..13).
- Counter state machine:
  - EMPTY: `bcnt`=0.
  - PARTIAL: 1..12.
  - FULL: 13; the counter saturates here and further shifts keep it at 13.
- Shift (`serial_shift`=1, `serial_load`=0): `shreg <= {shreg[11:0], serial_data_in}`; `bcnt <= min(bcnt+1, 13)`.
- Load (`serial_load`=1):
  - If `bcnt`=13: `shadow <= shreg`, pulse `load_ok`.
  - Otherwise: `shadow` unchanged, pulse `load_err`.
  - Either way, `bcnt <= 0`.
- Simultaneous shift and load: load wins and the shift is dropped that cycle (`shreg` holds, `serial_data_out` holds).
- Neither shift nor load asserted: everything holds.
- Pad data mux, combinational from `shadow`:
  - `mgmt_ena`=1: `pad_gpio_out`=`mgmt_gpio_out`; `pad_gpio_oeb`=`mgmt_gpio_oeb | oeb_ovr`; `mgmt_gpio_in`=`pad_gpio_in`; `user_gpio_in`=0.
  - `mgmt_ena`=0: user ports take the same roles; `mgmt_gpio_in`=0.
  - `inp_dis`=1 forces both `*_gpio_in` to 0.
- `pad_ctrl` = `shadow`, driven directly from flops with no logic after them.

## Timing
- Reset (async assert) sets:
  - `shreg` and `shadow` to `PAD_CTRL_DEFAULT`;
  - `bcnt`=0;
  - `serial_data_out`=`PAD_CTRL_DEFAULT[12]`=0;
  - `load_ok`=`load_err`=0;
  - `pad_ctrl`=13'h0403.
- Reset mid-shift or mid-load: the partial word is discarded and the outputs return to the reset values immediately; there is no glitch beyond the async transition.
- Chain latency: 1 cycle per stage. A bit applied at edge n appears on `serial_data_out` after 13 shifts of this stage.
- Load latency: `pad_ctrl` updates on the edge that samples `serial_load`. `load_ok`/`load_err` assert in the following cycle, for exactly 1 cycle.
- A load strobe held high for k cycles: the first cycle evaluates normally and the remaining k−1 see `bcnt`=0, so they pulse `load_err` and leave the shadow intact.
- Pad mux paths are purely combinational, with no registered latency.

## Structure
- Shared package `gpio_cfg_pkg` holds:
  - `CFG_W`;
  - bit-index localparams (`MGMT_ENA_BIT` … `DM_LSB`/`DM_MSB`);
  - `PAD_CTRL_DEFAULT`;
  - the `pad_ctrl_t` packed struct.
- One sub-module, `gpio_cfg_shifter`: holds `shreg`, `bcnt`, and load validation, and outputs `shadow` plus the pulses. The top level adds the pad mux only.

## Test plan
- Reset, no stimulus: `pad_ctrl`=13'h0403; `pad_gpio_oeb`=1 regardless of `mgmt_gpio_oeb`; `serial_data_out`=0; no pulses.
- Shift 13 bits of 13'h1C05 MSB-first, then one load strobe: `pad_ctrl`=13'h1C05 on the strobe edge; `load_ok` pulses once; `bcnt` returns to 0.
- Shift 7 bits, then load: `load_err` pulses; `pad_ctrl` stays 13'h0403.
- Shift 20 bits, then load: `bcnt` saturates at 13, `load_ok` pulses, `shadow` equals the last 13 bits shifted, and the first 7 bits appear on `serial_data_out` during shifts 14–20.
- Assert `serial_shift` and `serial_load` together with `bcnt`=13: `shadow` takes the pre-edge `shreg`, `shreg` is unchanged, and `load_ok` pulses.
- Load `mgmt_ena`=0 and `inp_dis`=0, then toggle `user_gpio_out`: it follows on `pad_gpio_out`; `pad_gpio_in`=1 gives `user_gpio_in`=1 and `mgmt_gpio_in`=0. Assert `reset` mid-sequence: everything returns to the defaults asynchronously.
